// File: rtl/conv_loop_ctrl_pkg.sv
// Shared types and constants for the convolution loop controller.
// Holds the FSM encoding, datapath widths and the issue-to-accumulate depth.
package conv_loop_ctrl_pkg;

    localparam int BYTE      = 8;
    localparam int HALF_WORD = 16;
    localparam int ISSUE_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/conv_loop_ctrl_loop_counter.sv
// Wrap counter: advances on inc, returns to zero after max and flags wrap that cycle.
// Zero latency on wrap; holds value while inc is low.
module loop_counter
    import conv_loop_ctrl_pkg::*;
#(
    parameter int W = BYTE
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic [W-1:0] max,
    output logic [W-1:0] value,
    output logic         wrap
);

    logic [W-1:0] r_value;

    assign value = r_value;
    assign wrap  = inc && (r_value == max);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
        end else if (wrap) begin
            r_value <= '0;
        end else if (inc) begin
            r_value <= r_value + 1'b1;
        end
    end

endmodule

// File: rtl/conv_loop_ctrl.sv
// Convolution loop nest j,k,i,m,n,l; accumulate strobes trail issue by ISSUE_LAT cycles, stall freezes issue only.
// Optional CONV_PAD_SKIP_EN flags taps falling in the zero-padding border via pad_zero.
module conv_loop_ctrl
    import conv_loop_ctrl_pkg::*;
#(
    parameter logic [7:0] CONV_DIM_IMG    = 8'd32,
    parameter logic [7:0] CONV_DIM_KERNEL = 8'd5,
    parameter logic [7:0] CONV_DIM_CH     = 8'd3,
    parameter logic [7:0] CONV_OUT_CH     = 8'd32,
    parameter logic [7:0] CONV_DIM_OUT    = 8'd32,
    parameter logic [7:0] STRIDE          = 8'd1,
    parameter logic [7:0] PADDING         = 8'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stall,
    output logic [7:0] i,
    output logic [7:0] j,
    output logic [7:0] k,
    output logic [7:0] l,
    output logic [7:0] m,
    output logic [7:0] n,
    output logic       enable,
    output logic       acc_clr,
    output logic       acc_en,
    output logic       en_save,
    output logic       pad_zero,
    output logic       busy,
    output logic       done
);

    localparam logic [BYTE-1:0] MAX_CH  = CONV_DIM_CH - 8'd1;
    localparam logic [BYTE-1:0] MAX_K   = CONV_DIM_KERNEL - 8'd1;
    localparam logic [BYTE-1:0] MAX_OC  = CONV_OUT_CH - 8'd1;
    localparam logic [BYTE-1:0] MAX_OUT = CONV_DIM_OUT - 8'd1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_enable;
    logic                 w_wrap_l, w_wrap_n, w_wrap_m, w_wrap_i, w_wrap_k, w_wrap_j;
    logic                 w_first, w_last, w_drain_done;
    logic [ISSUE_LAT-1:0] r_vld, r_first, r_last;
    logic                 r_save;

    assign w_enable = (r_state == ST_RUN) && !stall;

    // Innermost first: each counter advances when the one inside it wraps.
    loop_counter #(.W(BYTE)) u_cnt_l (.clk(clk), .reset(reset), .inc(w_enable), .max(MAX_CH),  .value(l), .wrap(w_wrap_l));
    loop_counter #(.W(BYTE)) u_cnt_n (.clk(clk), .reset(reset), .inc(w_wrap_l), .max(MAX_K),   .value(n), .wrap(w_wrap_n));
    loop_counter #(.W(BYTE)) u_cnt_m (.clk(clk), .reset(reset), .inc(w_wrap_n), .max(MAX_K),   .value(m), .wrap(w_wrap_m));
    loop_counter #(.W(BYTE)) u_cnt_i (.clk(clk), .reset(reset), .inc(w_wrap_m), .max(MAX_OC),  .value(i), .wrap(w_wrap_i));
    loop_counter #(.W(BYTE)) u_cnt_k (.clk(clk), .reset(reset), .inc(w_wrap_i), .max(MAX_OUT), .value(k), .wrap(w_wrap_k));
    loop_counter #(.W(BYTE)) u_cnt_j (.clk(clk), .reset(reset), .inc(w_wrap_k), .max(MAX_OUT), .value(j), .wrap(w_wrap_j));

    assign w_first = (m == '0) && (n == '0) && (l == '0);
    assign w_last  = (m == MAX_K) && (n == MAX_K) && (l == MAX_CH);

    // Drain ends once the final tap reaches the accumulator with nothing behind it.
    assign w_drain_done = r_vld[ISSUE_LAT-1] && (r_vld[ISSUE_LAT-2:0] == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = ST_RUN;
            end
            ST_RUN:    if (w_wrap_j) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (w_drain_done) w_state_nxt = ST_FINISH;
            ST_FINISH: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld   <= '0;
            r_first <= '0;
            r_last  <= '0;
            r_save  <= 1'b0;
        end else begin
            r_vld   <= {r_vld[ISSUE_LAT-2:0], w_enable};
            r_first <= {r_first[ISSUE_LAT-2:0], w_first};
            r_last  <= {r_last[ISSUE_LAT-2:0], w_last};
            r_save  <= r_vld[ISSUE_LAT-1] && r_last[ISSUE_LAT-1];
        end
    end

    assign enable  = w_enable;
    assign acc_en  = r_vld[ISSUE_LAT-1];
    assign acc_clr = r_vld[ISSUE_LAT-1] && r_first[ISSUE_LAT-1];
    assign en_save = r_save;

`ifdef CONV_PAD_SKIP_EN
    logic [BYTE-1:0]      w_sj, w_sk;
    logic signed [8:0]    w_row, w_col;
    logic                 w_pad;
    logic [ISSUE_LAT-1:0] r_pad;

    assign w_sj  = STRIDE * j;
    assign w_sk  = STRIDE * k;
    assign w_row = $signed({1'b0, w_sj}) + $signed({1'b0, m}) - $signed({1'b0, PADDING});
    assign w_col = $signed({1'b0, w_sk}) + $signed({1'b0, n}) - $signed({1'b0, PADDING});
    assign w_pad = w_row[8] || w_col[8] ||
                   (w_row >= $signed({1'b0, CONV_DIM_IMG})) ||
                   (w_col >= $signed({1'b0, CONV_DIM_IMG}));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pad <= '0;
        end else begin
            r_pad <= {r_pad[ISSUE_LAT-2:0], w_pad};
        end
    end

    assign pad_zero = r_vld[ISSUE_LAT-1] && r_pad[ISSUE_LAT-1];
`else
    assign pad_zero = 1'b0;
`endif

endmodule

// File: tb/tb_conv_loop_ctrl.sv
// Bench for conv_loop_ctrl: four parameterisations driven cycle by cycle against a tap-list model.
// Covers reset, tiny pass, stall, padding, mid-pass reset, ignored restart and a partial default-size pass.
module tb_conv_loop_ctrl;

`ifdef CONV_PAD_SKIP_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam int NCFG = 4;
    localparam int P_IMG [NCFG] = '{2, 32, 32, 32};
    localparam int P_K   [NCFG] = '{1, 3, 5, 5};
    localparam int P_CH  [NCFG] = '{1, 1, 3, 3};
    localparam int P_OC  [NCFG] = '{2, 1, 2, 32};
    localparam int P_DO  [NCFG] = '{2, 1, 2, 32};
    localparam int P_S   [NCFG] = '{1, 1, 1, 1};
    localparam int P_PAD [NCFG] = '{0, 2, 2, 2};

    typedef struct {
        int j; int k; int i; int m; int n; int l;
    } tap_t;

    logic       clk;
    logic       rst  [NCFG];
    logic       go   [NCFG];
    logic       stl  [NCFG];
    logic [7:0] o_i [NCFG], o_j [NCFG], o_k [NCFG], o_l [NCFG], o_m [NCFG], o_n [NCFG];
    logic       o_en [NCFG], o_clr [NCFG], o_acc [NCFG], o_save [NCFG];
    logic       o_pad [NCFG], o_busy [NCFG], o_done [NCFG];

    int n_cmp, n_err;
    int cnt_en, cnt_acc, cnt_clr, cnt_save, cnt_done, cnt_pad0, cnt_en_win, cnt_post;
    int m_issued, last_en_c, done_c;
    bit m_finished;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        conv_loop_ctrl #(
            .CONV_DIM_IMG   (8'(P_IMG[g])),
            .CONV_DIM_KERNEL(8'(P_K[g])),
            .CONV_DIM_CH    (8'(P_CH[g])),
            .CONV_OUT_CH    (8'(P_OC[g])),
            .CONV_DIM_OUT   (8'(P_DO[g])),
            .STRIDE         (8'(P_S[g])),
            .PADDING        (8'(P_PAD[g]))
        ) u_dut (
            .clk(clk), .reset(rst[g]), .start(go[g]), .stall(stl[g]),
            .i(o_i[g]), .j(o_j[g]), .k(o_k[g]), .l(o_l[g]), .m(o_m[g]), .n(o_n[g]),
            .enable(o_en[g]), .acc_clr(o_clr[g]), .acc_en(o_acc[g]), .en_save(o_save[g]),
            .pad_zero(o_pad[g]), .busy(o_busy[g]), .done(o_done[g])
        );
    end

    // Tap number -> loop indices, l varying fastest and j slowest.
    function automatic tap_t decode(input int g, input int idx);
        tap_t t;
        int   r;
        r   = idx;
        t.l = r % P_CH[g]; r = r / P_CH[g];
        t.n = r % P_K[g];  r = r / P_K[g];
        t.m = r % P_K[g];  r = r / P_K[g];
        t.i = r % P_OC[g]; r = r / P_OC[g];
        t.k = r % P_DO[g]; r = r / P_DO[g];
        t.j = r;
        return t;
    endfunction

    function automatic bit is_pad(input int g, input tap_t t);
        int row, col;
        row = P_S[g] * t.j + t.m - P_PAD[g];
        col = P_S[g] * t.k + t.n - P_PAD[g];
        return PAD_EN && (row < 0 || row >= P_IMG[g] || col < 0 || col >= P_IMG[g]);
    endfunction

    // mode: 0 no stall, 1 stall cycles 3..6, 2 random stall (also with start in IDLE).
    task automatic run_pass(input int g, input int mode, input bit restart, input int reset_at,
                            input int max_cycles);
        int          total, tpo, issued, done_at, acc_seen;
        int          due_q[$];
        int          idx_q[$];
        bit          run, s, e_en, e_acc, e_clr, e_pad, e_save, e_busy, save_next, aborted;
        tap_t        cur, t;
        logic [47:0] e_idx, d_idx;
        total    = P_DO[g] * P_DO[g] * P_OC[g] * P_K[g] * P_K[g] * P_CH[g];
        tpo      = P_K[g] * P_K[g] * P_CH[g];
        issued   = 0; done_at = -1; acc_seen = 0; save_next = 1'b0; aborted = 1'b0;
        cnt_en   = 0; cnt_acc = 0; cnt_clr = 0; cnt_save = 0; cnt_done = 0;
        cnt_pad0 = 0; cnt_en_win = 0; cnt_post = 0;
        last_en_c = -1; done_c = -1; m_finished = 1'b0;
        @(negedge clk);
        rst[g] = 1'b1; go[g] = 1'b0; stl[g] = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            if (reset_at >= 0 && c == reset_at + 1) begin
                aborted = 1'b1; due_q.delete(); idx_q.delete(); save_next = 1'b0;
            end
            run = (c >= 1) && (issued < total) && !aborted;
            case (mode)
                1:       s = (c >= 3) && (c < 7);
                2:       s = ($urandom_range(3, 0) == 0) || (c == 0);
                default: s = 1'b0;
            endcase
            rst[g] = (c == reset_at);
            go[g]  = (c == 0) || (restart && run && (c % 7 == 3));
            stl[g] = s;
            #1;
            e_en  = run && !s;
            cur   = decode(g, issued);
            e_idx = run ? {8'(cur.i), 8'(cur.j), 8'(cur.k), 8'(cur.l), 8'(cur.m), 8'(cur.n)} : '0;
            d_idx = {o_i[g], o_j[g], o_k[g], o_l[g], o_m[g], o_n[g]};
            e_acc = (due_q.size() > 0) && (due_q[0] == c);
            e_clr = 1'b0; e_pad = 1'b0;
            if (e_acc) begin
                void'(due_q.pop_front());
                t     = decode(g, idx_q.pop_front());
                e_clr = (t.m == 0) && (t.n == 0) && (t.l == 0);
                e_pad = is_pad(g, t);
            end
            e_save    = save_next;
            save_next = e_acc && (t.m == P_K[g] - 1) && (t.n == P_K[g] - 1) && (t.l == P_CH[g] - 1);
            e_busy    = (c >= 1) && !aborted && (done_at < 0 || c <= done_at);

            n_cmp++; if (o_en[g] !== e_en) begin n_err++; $display("FAIL enable g%0d c%0d got %b want %b", g, c, o_en[g], e_en); end
            n_cmp++; if (d_idx !== e_idx) begin n_err++; $display("FAIL indices(ijklmn) g%0d c%0d got %h want %h", g, c, d_idx, e_idx); end
            n_cmp++; if (o_acc[g] !== e_acc) begin n_err++; $display("FAIL acc_en g%0d c%0d got %b want %b", g, c, o_acc[g], e_acc); end
            n_cmp++; if (o_clr[g] !== e_clr) begin n_err++; $display("FAIL acc_clr g%0d c%0d got %b want %b", g, c, o_clr[g], e_clr); end
            n_cmp++; if (o_pad[g] !== e_pad) begin n_err++; $display("FAIL pad_zero g%0d c%0d got %b want %b", g, c, o_pad[g], e_pad); end
            n_cmp++; if (o_save[g] !== e_save) begin n_err++; $display("FAIL en_save g%0d c%0d got %b want %b", g, c, o_save[g], e_save); end
            n_cmp++; if (o_done[g] !== (c == done_at)) begin n_err++; $display("FAIL done g%0d c%0d got %b want %b", g, c, o_done[g], (c == done_at)); end
            n_cmp++; if (o_busy[g] !== e_busy) begin n_err++; $display("FAIL busy g%0d c%0d got %b want %b", g, c, o_busy[g], e_busy); end

            if (o_en[g] === 1'b1) begin cnt_en++; last_en_c = c; end
            if (o_en[g] === 1'b1 && s) cnt_en_win++;
            if (o_acc[g] === 1'b1) cnt_acc++;
            if (o_clr[g] === 1'b1) cnt_clr++;
            if (o_save[g] === 1'b1) cnt_save++;
            if (o_done[g] === 1'b1) begin cnt_done++; done_c = c; end
            if (aborted && (o_save[g] === 1'b1 || o_done[g] === 1'b1)) cnt_post++;
            if (o_acc[g] === 1'b1 && acc_seen < tpo) begin
                acc_seen++;
                if (o_pad[g] === 1'b1) cnt_pad0++;
            end

            if (e_en) begin
                due_q.push_back(c + 2);
                idx_q.push_back(issued);
                issued++;
                if (issued == total) done_at = c + 3;
            end
            if (done_at >= 0 && c > done_at) begin m_finished = 1'b1; break; end
            if (aborted && c > reset_at + 12) break;
        end
        m_issued = issued;
        rst[g] = 1'b0; go[g] = 1'b0; stl[g] = 1'b0;
    endtask

    task automatic test_reset();
        for (int g = 0; g < NCFG; g++) begin rst[g] = 1'b1; go[g] = 1'b1; stl[g] = 1'b1; end
        repeat (3) @(negedge clk);
        #1;
        for (int g = 0; g < NCFG; g++) begin
            n_cmp++; if ({o_i[g], o_j[g], o_k[g], o_l[g], o_m[g], o_n[g]} !== 48'h0) begin n_err++; $display("FAIL reset_indices g%0d got %h want 0", g, {o_i[g], o_j[g], o_k[g], o_l[g], o_m[g], o_n[g]}); end
            n_cmp++; if ({o_en[g], o_clr[g], o_acc[g], o_save[g], o_pad[g], o_done[g]} !== 6'b0) begin n_err++; $display("FAIL reset_strobes g%0d got %b want 000000", g, {o_en[g], o_clr[g], o_acc[g], o_save[g], o_pad[g], o_done[g]}); end
            n_cmp++; if (o_busy[g] !== 1'b0) begin n_err++; $display("FAIL reset_busy g%0d got %b want 0", g, o_busy[g]); end
        end
        for (int g = 0; g < NCFG; g++) begin go[g] = 1'b0; stl[g] = 1'b0; end
    endtask

    task automatic test_tiny();
        run_pass(0, 0, 1'b0, -1, 60);
        n_cmp++; if (m_finished !== 1'b1) begin n_err++; $display("FAIL tiny_timeout got %b want 1", m_finished); end
        n_cmp++; if (cnt_en != 8) begin n_err++; $display("FAIL tiny_enable_count got %0d want 8", cnt_en); end
        n_cmp++; if (cnt_acc != 8) begin n_err++; $display("FAIL tiny_acc_count got %0d want 8", cnt_acc); end
        n_cmp++; if (cnt_clr != 8) begin n_err++; $display("FAIL tiny_clr_count got %0d want 8", cnt_clr); end
        n_cmp++; if (cnt_save != 8) begin n_err++; $display("FAIL tiny_save_count got %0d want 8", cnt_save); end
        n_cmp++; if (done_c - last_en_c != 3) begin n_err++; $display("FAIL tiny_done_latency got %0d want 3", done_c - last_en_c); end
    endtask

    task automatic test_stall();
        run_pass(1, 1, 1'b0, -1, 60);
        n_cmp++; if (m_finished !== 1'b1) begin n_err++; $display("FAIL stall_timeout got %b want 1", m_finished); end
        n_cmp++; if (cnt_en_win != 0) begin n_err++; $display("FAIL stall_enable_during_stall got %0d want 0", cnt_en_win); end
        n_cmp++; if (cnt_acc != 9) begin n_err++; $display("FAIL stall_acc_count got %0d want 9", cnt_acc); end
        n_cmp++; if (cnt_save != 1) begin n_err++; $display("FAIL stall_save_count got %0d want 1", cnt_save); end
    endtask

    task automatic test_padding();
        int want;
        want = PAD_EN ? 16 * P_CH[2] : 0;
        run_pass(2, 0, 1'b0, -1, 1500);
        n_cmp++; if (m_finished !== 1'b1) begin n_err++; $display("FAIL pad_timeout got %b want 1", m_finished); end
        n_cmp++; if (cnt_pad0 != want) begin n_err++; $display("FAIL pad_first_output got %0d want %0d", cnt_pad0, want); end
        n_cmp++; if (cnt_save != 8) begin n_err++; $display("FAIL pad_save_count got %0d want 8", cnt_save); end
    endtask

    task automatic test_reset_mid();
        run_pass(2, 0, 1'b0, 10, 100);
        n_cmp++; if (cnt_post != 0) begin n_err++; $display("FAIL midreset_save_or_done got %0d want 0", cnt_post); end
        n_cmp++; if (m_finished !== 1'b0) begin n_err++; $display("FAIL midreset_completed got %b want 0", m_finished); end
    endtask

    task automatic test_restart();
        run_pass(2, 2, 1'b1, -1, 3000);
        n_cmp++; if (m_finished !== 1'b1) begin n_err++; $display("FAIL restart_timeout got %b want 1", m_finished); end
        n_cmp++; if (cnt_save != P_DO[2] * P_DO[2] * P_OC[2]) begin n_err++; $display("FAIL restart_save_count got %0d want %0d", cnt_save, P_DO[2] * P_DO[2] * P_OC[2]); end
        n_cmp++; if (cnt_done != 1) begin n_err++; $display("FAIL restart_done_count got %0d want 1", cnt_done); end
    endtask

    task automatic test_defaults();
        run_pass(3, 2, 1'b0, -1, 3000);
        n_cmp++; if (cnt_en != m_issued) begin n_err++; $display("FAIL default_enable_count got %0d want %0d", cnt_en, m_issued); end
        n_cmp++; if (m_finished !== 1'b0) begin n_err++; $display("FAIL default_early_finish got %b want 0", m_finished); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_tiny();
        test_stall();
        test_padding();
        test_reset_mid();
        test_restart();
        test_defaults();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_loop_ctrl.md
CONV_LOOP_CTRL -- requirements
Module: conv_loop_ctrl

Interface
REQ-001 SHALL have parameters, all 8-bit: CONV_DIM_IMG, default 32, input image width/height; CONV_DIM_KERNEL, default 5, kernel width/height; CONV_DIM_CH, default 3, input channels; CONV_OUT_CH, default 32, output channels; CONV_DIM_OUT, default 32, output width/height; STRIDE, default 1, convolution stride; PADDING, default 2, zero-padding border.
REQ-002 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  begin one layer pass.
- stall  in  1  memory not ready; freeze issue.
- i, j, k, l, m, n  out  8 each  output-channel, out-row, out-col, in-channel, kernel-row, kernel-col indices.
- enable  out  1  address-generator capture strobe.
- acc_clr  out  1  clear accumulator.
- acc_en  out  1  accumulate returned operand pair.
- en_save  out  1  store finished output.
- pad_zero  out  1  current accumulated tap lies in the padding border.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pass-complete pulse.

Function
REQ-003 SHALL use loop order, outermost first: j, k, i, m, n, l; l increments fastest.
REQ-004 SHALL wrap each index at its bound (j,k: CONV_DIM_OUT; i: CONV_OUT_CH; m,n: CONV_DIM_KERNEL; l: CONV_DIM_CH) and carry into the next-outer index.
REQ-005 SHALL implement the FSM IDLE -> RUN -> DRAIN -> FINISH -> IDLE.
REQ-006 IDLE: all indices 0, busy 0; start=1 -> RUN on the next edge.
REQ-007 RUN: each non-stalled cycle issues one tap, with enable=1 and indices advancing by one step; busy=1.
REQ-008 SHALL hold indices while stall=1, drive enable=0, and inject a bubble into the issue pipeline.
REQ-009 SHALL track a 2-stage valid pipeline (address register + memory read): acc_en equals issue-valid delayed 2 cycles.
REQ-010 SHALL pulse acc_clr together with the acc_en of the first tap (m=n=l=0) of each output.
REQ-011 SHALL pulse en_save one cycle after the acc_en of the last tap (m,n,l all at max) of each output.
REQ-012 SHALL enter DRAIN after issuing the final tap (all indices at max). DRAIN SHALL last until the final en_save has been emitted, then go to FINISH.
REQ-013 FINISH: done=1 for exactly one cycle, then IDLE; indices SHALL return to 0.
REQ-014 SHALL ignore start outside IDLE.
REQ-015 SHALL ignore stall during DRAIN, because the pipeline is already issued.
REQ-016 SHALL keep indices at their post-reset value of 0 while start and stall are high simultaneously in IDLE; stall is evaluated from RUN onward.
REQ-017 SHALL do all bound comparisons in 8-bit unsigned, plus a 9-bit signed intermediate for padding checks.

Reset
REQ-018 On reset=1 at a clock edge, SHALL force IDLE, clear all indices, and deassert enable, acc_clr, acc_en, en_save, pad_zero, busy and done. This applies mid-pass as well: the pipeline valid bits are flushed, and no en_save or done follows the abort.

Configuration
REQ-019 SHALL support the macro CONV_PAD_SKIP_EN.
REQ-020 With CONV_PAD_SKIP_EN defined: per tap, row = STRIDE*j+m-PADDING and col = STRIDE*k+n-PADDING. If row or col is <0 or >=CONV_DIM_IMG, pad_zero SHALL assert, aligned with that tap's acc_en.
REQ-021 Without CONV_PAD_SKIP_EN: pad_zero SHALL be tied to 0 and the padding logic SHALL be absent.

Structure
REQ-022 Shared package/header SHALL hold: FSM state encodings (2-bit), the BYTE/HALF_WORD width constants, and the pipeline depth constant ISSUE_LAT=2.
REQ-023 SHALL contain one sub-module, loop_counter: a parameterized wrap counter with inputs inc and max, and outputs value and wrap, instantiated six times and chained by wrap.

Verification
REQ-024 The bench SHALL cover the following scenarios:
- Tiny pass (K=1, CH=1, OUT_CH=2, DIM_OUT=2, PADDING=0): start -> 8 enable pulses, 8 acc_en, 8 acc_clr, 8 en_save; done 3 cycles after the last enable.
- Stall (K=3, CH=1, OUT_CH=1, DIM_OUT=1): stall high for 4 cycles mid-RUN -> indices frozen, enable=0 for those 4 cycles; still exactly 9 acc_en and 1 en_save.
- Padding with CONV_PAD_SKIP_EN (K=5, PADDING=2, IMG=32): the first output (j=k=0) shows 16 of 25 taps per channel with pad_zero=1.
- Reset mid-pass: reset asserted 10 cycles after start -> busy=0 next cycle, no en_save or done afterward.
- start re-asserted during RUN: no effect; the total en_save count equals CONV_DIM_OUT²·CONV_OUT_CH.
- Defaults: the total number of enable pulses equals 32·32·32·75 = 2,457,600.
